// File: rtl/counter_5bit_if.sv
// counter_5bit_if: control/status bundle for the up/down counter.
interface counter_5bit_if #(parameter int WIDTH = 5);
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  modport master (output en, up, clr, load, load_val, input count, tc, wrap);
  modport slave  (input en, up, clr, load, load_val, output count, tc, wrap);
endinterface

// File: rtl/counter_5bit.sv
// counter_5bit: up/down counter with clear, load, terminal-count and wrap pulse.
// Define COUNTER_SAT_EN to saturate at the ends instead of wrapping.
module counter_5bit #(
  parameter int WIDTH       = 5,
  parameter int RESET_VALUE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  counter_5bit_if.slave  bus
);
  logic [WIDTH-1:0] count_q, count_d, step;
  logic             wrap_q, wrap_d, at_end;
  always_comb begin
    at_end  = bus.up ? (count_q == '1) : (count_q == '0);
`ifdef COUNTER_SAT_EN
    step    = at_end ? count_q : bus.up ? count_q + 1'b1 : count_q - 1'b1;
    wrap_d  = 1'b0;
`else
    step    = bus.up ? count_q + 1'b1 : count_q - 1'b1;
    wrap_d  = !bus.clr && !bus.load && bus.en && at_end;
`endif
    count_d = bus.clr ? '0 : bus.load ? bus.load_val : bus.en ? step : count_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count_q <= WIDTH'(RESET_VALUE);
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = at_end;
endmodule

// File: tb/tb_counter_5bit.sv
// tb_counter_5bit: directed self-checking bench for counter_5bit.
module tb_counter_5bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  counter_5bit_if #(.WIDTH(5)) bus ();
  counter_5bit #(.WIDTH(5), .RESET_VALUE(0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cw(input string tag, input logic [4:0] c, input logic w, input logic t);
    check({tag, ".count"}, 32'(bus.count), 32'(c));
    check({tag, ".wrap"}, 32'(bus.wrap), 32'(w));
    check({tag, ".tc"}, 32'(bus.tc), 32'(t));
  endtask
  initial begin
    bus.en = 0; bus.up = 0; bus.clr = 0; bus.load = 0; bus.load_val = '0;
    #2;
    cw("reset", 5'd0, 1'b0, 1'b1);
    tick();
    cw("reset_held", 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1; bus.en = 1; bus.up = 1;
    tick(); cw("up1", 5'd1, 1'b0, 1'b0);
    tick(); cw("up2", 5'd2, 1'b0, 1'b0);
    tick(); cw("up3", 5'd3, 1'b0, 1'b0);
    bus.load = 1; bus.load_val = 5'd30;
    tick(); cw("load30", 5'd30, 1'b0, 1'b0);
    bus.load = 0;
`ifdef COUNTER_SAT_EN
    tick(); cw("sat31", 5'd31, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); cw("sat_hi", 5'd31, 1'b0, 1'b1);
    end
    bus.load = 1; bus.load_val = 5'd0; bus.up = 0;
    tick(); cw("sat_load0", 5'd0, 1'b0, 1'b1);
    bus.load = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); cw("sat_lo", 5'd0, 1'b0, 1'b1);
    end
    bus.up = 1;
`else
    tick(); cw("up31", 5'd31, 1'b0, 1'b1);
    tick(); cw("upwrap", 5'd0, 1'b1, 1'b0);
    tick(); cw("after_upwrap", 5'd1, 1'b0, 1'b0);
    bus.clr = 1;
    tick(); cw("clr", 5'd0, 1'b0, 1'b0);
    bus.clr = 0; bus.up = 0;
    #1; cw("tc_down0", 5'd0, 1'b0, 1'b1);
    tick(); cw("dnwrap", 5'd31, 1'b1, 1'b0);
    tick(); cw("dn30", 5'd30, 1'b0, 1'b0);
    bus.up = 1;
`endif
    bus.clr = 1; bus.load = 1; bus.load_val = 5'd20; bus.en = 1;
    tick(); cw("prio_clr", 5'd0, 1'b0, 1'b0);
    bus.clr = 0;
    tick(); cw("prio_load", 5'd20, 1'b0, 1'b0);
    bus.load = 0; bus.en = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); cw("hold", 5'd20, 1'b0, 1'b0);
    end
    bus.en = 1; bus.load = 1; bus.load_val = 5'd16;
    tick(); cw("load16", 5'd16, 1'b0, 1'b0);
    bus.load = 0;
    tick(); cw("cnt17", 5'd17, 1'b0, 1'b0);
    #3 rst_n = 0;
    #1 cw("rst_mid", 5'd0, 1'b0, 1'b0);
    #1 rst_n = 1;
    tick(); cw("resume1", 5'd1, 1'b0, 1'b0);
    tick(); cw("resume2", 5'd2, 1'b0, 1'b0);
    // reset held across an edge must beat a simultaneous clr/load
    bus.load = 1; bus.clr = 1; bus.load_val = 5'd9; rst_n = 0;
    tick(); cw("rst_over_load", 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1; bus.clr = 0; bus.load = 0;
    tick(); cw("post_rst", 5'd1, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
